// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control path.
//   state_e   : FSM state encoding (also exported on state_o for debug)
//   opclass_e : instruction class latched in DECODE
//   OP_*      : major opcode values (inst_code[6:0])
//   ALU_*     : alu_op select codes
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    OC_NONE   = 3'd0,
    OC_LOAD   = 3'd1,
    OC_OPIMM  = 3'd2,
    OC_OP     = 3'd3,
    OC_STORE  = 3'd4,
    OC_BRANCH = 3'd5
  } opclass_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_CMP   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Single-port memory handshake between the control FSM and the memory.
//   mem_req      : request active (controller -> memory)
//   mem_we       : write when mem_req (controller -> memory)
//   mem_addr_sel : 0 = PC, 1 = ALU result (controller -> address mux)
//   mem_ready    : memory completes the request this cycle (memory -> controller)
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl_op_classify.sv
// Combinational major-opcode classifier.
//   i_opcode : inst_code[6:0]
//   o_class  : supported instruction class, OC_NONE if unsupported
//   o_valid  : 1 when the opcode belongs to the supported subset
module op_classify
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output opclass_e   o_class,
  output logic       o_valid
);

  always_comb begin
    o_class = OC_NONE;
    o_valid = 1'b1;
    case (i_opcode)
      OP_LOAD:   o_class = OC_LOAD;
      OP_OPIMM:  o_class = OC_OPIMM;
      OP_OP:     o_class = OC_OP;
      OP_STORE:  o_class = OC_STORE;
      OP_BRANCH: o_class = OC_BRANCH;
      default:   o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I subset (load, OP-IMM, OP, store,
// branch). Sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory port and
// drives the datapath selects. Keeps a retired-instruction counter.
//   clk, reset   : clock, synchronous active-high reset
//   mbus         : memory handshake (master side)
//   inst_code    : IR contents, stable from DECODE until the next fetch
//   branch_taken : comparator result, used in EXEC of a branch
//   ir_write, pc_write, pc_src, alu_src_b, alu_op, reg_write, wb_sel :
//                  datapath controls
//   illegal      : one-cycle pulse on an unsupported opcode
//   instret      : retired-instruction count
//   state_o      : current state for debug
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  mbus,
  input  logic [31:0]        inst_code,
  input  logic               branch_taken,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic               alu_src_b,
  output logic [1:0]         alu_op,
  output logic               reg_write,
  output logic               wb_sel,
  output logic               illegal,
  output logic [31:0]        instret,
  output logic [2:0]         state_o
);

  state_e      r_state;
  state_e      w_next;
  opclass_e    r_opclass;
  logic [31:0] r_instret;

  opclass_e    w_class;
  logic        w_class_valid;

  logic        w_mem_req;
  logic        w_mem_we;
  logic        w_mem_addr_sel;

  // Only the major opcode matters to the control path.
  logic        w_unused_ir;
  assign w_unused_ir = ^inst_code[31:7];

  op_classify u_classify (
    .i_opcode (inst_code[6:0]),
    .o_class  (w_class),
    .o_valid  (w_class_valid)
  );

  // State register, class latch and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_opclass <= OC_NONE;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_opclass <= w_class;
      end
      // An instruction retires in the cycle it commits the PC update.
      if (pc_write && !illegal) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (mbus.mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_class_valid)     w_next = S_EXEC;
        else if (ILLEGAL_HALT) w_next = S_HALT;
        else                   w_next = S_FETCH;
      end
      S_EXEC: begin
        case (r_opclass)
          OC_LOAD, OC_STORE: w_next = S_MEM;
          OC_OPIMM, OC_OP:   w_next = S_WB;
          default:           w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mbus.mem_ready) begin
          w_next = (r_opclass == OC_STORE) ? S_FETCH : S_WB;
        end
      end
      S_WB:    w_next = S_FETCH;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  // Output logic; reset masks every control so nothing commits in that cycle.
  always_comb begin
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr_sel = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    pc_src         = 1'b0;
    alu_src_b      = 1'b0;
    alu_op         = ALU_ADD;
    reg_write      = 1'b0;
    wb_sel         = 1'b0;
    illegal        = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        ir_write  = mbus.mem_ready;
      end
      S_DECODE: begin
        if (!w_class_valid) begin
          illegal  = 1'b1;
          pc_write = !ILLEGAL_HALT;
        end
      end
      S_EXEC: begin
        case (r_opclass)
          OC_LOAD, OC_STORE: begin
            alu_src_b = 1'b1;
            alu_op    = ALU_ADD;
          end
          OC_OPIMM: begin
            alu_src_b = 1'b1;
            alu_op    = ALU_FUNCT;
          end
          OC_OP: begin
            alu_op = ALU_FUNCT;
          end
          OC_BRANCH: begin
            alu_op   = ALU_CMP;
            pc_write = 1'b1;
            pc_src   = branch_taken;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_mem_req      = 1'b1;
        w_mem_addr_sel = 1'b1;
        alu_src_b      = 1'b1;
        w_mem_we       = (r_opclass == OC_STORE);
        pc_write       = mbus.mem_ready && (r_opclass == OC_STORE);
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (r_opclass == OC_LOAD);
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      w_mem_req      = 1'b0;
      w_mem_we       = 1'b0;
      w_mem_addr_sel = 1'b0;
      ir_write       = 1'b0;
      pc_write       = 1'b0;
      pc_src         = 1'b0;
      alu_src_b      = 1'b0;
      alu_op         = ALU_ADD;
      reg_write      = 1'b0;
      wb_sel         = 1'b0;
      illegal        = 1'b0;
    end
  end

  assign mbus.mem_req      = w_mem_req;
  assign mbus.mem_we       = w_mem_we;
  assign mbus.mem_addr_sel = w_mem_addr_sel;
  assign instret           = r_instret;
  assign state_o           = r_state;

endmodule
